// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
//   Shared core definitions: datapath width, canonical NOP encoding and the
//   types used by the unified-memory port arbiter (mem_port_arbiter).
//   No ports; import with `import riscv_pkg::*;`.
// -----------------------------------------------------------------------------
package riscv_pkg;

   localparam int XLEN = 32;

   // addi x0, x0, 0
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

   // Who owns the memory response that arrives next cycle.
   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_I    = 2'd1,
      OWN_D    = 2'd2
   } arb_owner_e;

   localparam int ARB_STARVE_LIMIT_DEFAULT = 4;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// -----------------------------------------------------------------------------
// mem_arb_starve_ctr
//   Saturating count of consecutive cycles a waiting fetch has lost
//   arbitration. hit is high once the count has reached LIMIT.
//   Ports:
//     clk    in   clock
//     reset  in   synchronous active-high reset (count -> 0)
//     inc    in   fetch waited and lost this cycle
//     clr    in   fetch granted or not requesting (count -> 0, wins over inc)
//     hit    out  count == LIMIT
//   Parameter LIMIT: 1..15.
// -----------------------------------------------------------------------------
module mem_arb_starve_ctr #(
   parameter int LIMIT = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic inc,
   input  logic clr,
   output logic hit
);

   localparam logic [3:0] LIMIT_W = 4'(LIMIT);

   logic [3:0] cnt_d;
   logic [3:0] cnt_q;

   function automatic logic [3:0] sat_inc(input logic [3:0] cnt);
      return (cnt >= LIMIT_W) ? LIMIT_W : cnt + 4'd1;
   endfunction

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc) begin
         cnt_d = sat_inc(cnt_q);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign hit = (cnt_q == LIMIT_W);

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-ported, synchronous-read memory between the instruction
//   fetch port (I) and the LSU data port (D). One grant per cycle, D wins by
//   default; response pulses one cycle after the grant. Out-of-range requests
//   take their slot but skip the memory and return an error response.
//
//   Build option: define MEM_ARB_STARVE_GUARD_EN to add the starvation guard
//   (a fetch that has lost STARVE_LIMIT consecutive cycles beats D). Without
//   it, D has strict priority.
//
//   Ports:
//     clk, reset                         clock, synchronous active-high reset
//     i_req_valid/addr, i_req_ready      fetch request handshake
//     i_flush                            cancel outstanding fetch, block I grant
//     i_rsp_valid/rdata/err              fetch response pulse
//     d_req_valid/we/addr/wdata/be,
//     d_req_ready                        data request handshake
//     d_rsp_valid/rdata/err              data response pulse (reads and writes)
//     mem_req/we/addr/wdata/be           memory strobe, combinational in grant cycle
//     mem_rdata                          memory read data, one cycle after mem_req
// -----------------------------------------------------------------------------
module mem_port_arbiter
   import riscv_pkg::*;
#(
   parameter int MEM_BYTES    = 16384,
   parameter int STARVE_LIMIT = ARB_STARVE_LIMIT_DEFAULT
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            i_req_valid,
   input  logic [XLEN-1:0] i_req_addr,
   output logic            i_req_ready,
   input  logic            i_flush,
   output logic            i_rsp_valid,
   output logic [XLEN-1:0] i_rsp_rdata,
   output logic            i_rsp_err,
   input  logic            d_req_valid,
   input  logic            d_req_we,
   input  logic [XLEN-1:0] d_req_addr,
   input  logic [XLEN-1:0] d_req_wdata,
   input  logic [3:0]      d_req_be,
   output logic            d_req_ready,
   output logic            d_rsp_valid,
   output logic [XLEN-1:0] d_rsp_rdata,
   output logic            d_rsp_err,
   output logic            mem_req,
   output logic            mem_we,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_wdata,
   output logic [3:0]      mem_be,
   input  logic [XLEN-1:0] mem_rdata
);

   localparam logic [XLEN-1:0] I_LIMIT = XLEN'(MEM_BYTES);
   localparam logic [XLEN-1:0] D_LIMIT = XLEN'(MEM_BYTES - 4);

   logic       starve_hit;
   logic       i_win;
   logic       d_win;
   logic       i_in_rng;
   logic       d_in_rng;

   arb_owner_e owner_d, owner_q;
   logic       err_d, err_q;
   logic       wr_d, wr_q;

`ifdef MEM_ARB_STARVE_GUARD_EN
   mem_arb_starve_ctr #(
      .LIMIT (STARVE_LIMIT)
   ) u_starve_ctr (
      .clk   (clk),
      .reset (reset),
      .inc   (i_req_valid && !i_req_ready && !i_flush),
      .clr   (i_win || !i_req_valid),
      .hit   (starve_hit)
   );
`else
   // Legal limits are 1..15, so this is constant 0: strict D priority.
   assign starve_hit = (STARVE_LIMIT == 0);
`endif

   // ---- Stage 0: arbitration, range check, memory drive ----
   always_comb begin
      i_in_rng  = (i_req_addr < I_LIMIT);
      d_in_rng  = (d_req_addr <= D_LIMIT);
      i_win     = !reset && i_req_valid && !i_flush && (!d_req_valid || starve_hit);
      d_win     = !reset && d_req_valid && !i_win;

      i_req_ready = i_win;
      d_req_ready = d_win;

      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_be    = 4'b0000;
      if (i_win && i_in_rng) begin
         mem_req  = 1'b1;
         mem_addr = {i_req_addr[XLEN-1:2], 2'b00};
      end else if (d_win && d_in_rng) begin
         mem_req   = 1'b1;
         mem_we    = d_req_we;
         mem_addr  = d_req_addr;
         mem_wdata = d_req_we ? d_req_wdata : '0;
         mem_be    = d_req_we ? d_req_be : 4'b0000;
      end

      owner_d = OWN_NONE;
      err_d   = 1'b0;
      wr_d    = 1'b0;
      if (i_win) begin
         owner_d = OWN_I;
         err_d   = !i_in_rng;
      end else if (d_win) begin
         owner_d = OWN_D;
         err_d   = !d_in_rng;
         wr_d    = d_req_we;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         owner_q <= OWN_NONE;
         err_q   <= 1'b0;
         wr_q    <= 1'b0;
      end else begin
         owner_q <= owner_d;
         err_q   <= err_d;
         wr_q    <= wr_d;
      end
   end

   // ---- Stage 1: response steering ----
   always_comb begin
      i_rsp_valid = !reset && (owner_q == OWN_I) && !i_flush;
      i_rsp_err   = i_rsp_valid && err_q;
      i_rsp_rdata = '0;
      if (i_rsp_valid) begin
         i_rsp_rdata = err_q ? NOP_INSTR : mem_rdata;
      end

      d_rsp_valid = !reset && (owner_q == OWN_D);
      d_rsp_err   = d_rsp_valid && err_q;
      d_rsp_rdata = '0;
      if (d_rsp_valid && !err_q && !wr_q) begin
         d_rsp_rdata = mem_rdata;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
   import riscv_pkg::*;

   logic            clk = 1'b0;
   logic            reset;
   logic            i_req_valid;
   logic [31:0]     i_req_addr;
   logic            i_req_ready;
   logic            i_flush;
   logic            i_rsp_valid;
   logic [31:0]     i_rsp_rdata;
   logic            i_rsp_err;
   logic            d_req_valid;
   logic            d_req_we;
   logic [31:0]     d_req_addr;
   logic [31:0]     d_req_wdata;
   logic [3:0]      d_req_be;
   logic            d_req_ready;
   logic            d_rsp_valid;
   logic [31:0]     d_rsp_rdata;
   logic            d_rsp_err;
   logic            mem_req;
   logic            mem_we;
   logic [31:0]     mem_addr;
   logic [31:0]     mem_wdata;
   logic [3:0]      mem_be;
   logic [31:0]     mem_rdata;

   int n_chk  = 0;
   int n_fail = 0;

   mem_port_arbiter #(.MEM_BYTES(16384), .STARVE_LIMIT(4)) dut (
      .clk(clk), .reset(reset),
      .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_ready(i_req_ready),
      .i_flush(i_flush), .i_rsp_valid(i_rsp_valid), .i_rsp_rdata(i_rsp_rdata),
      .i_rsp_err(i_rsp_err),
      .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_addr(d_req_addr),
      .d_req_wdata(d_req_wdata), .d_req_be(d_req_be), .d_req_ready(d_req_ready),
      .d_rsp_valid(d_rsp_valid), .d_rsp_rdata(d_rsp_rdata), .d_rsp_err(d_rsp_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Small memory model: 256 words, aliased on addr[9:2], word k starts as A000_0000+k.
   logic [31:0] mem [0:255];
   initial begin
      for (int k = 0; k < 256; k++) mem[k] = 32'hA000_0000 + k;
      mem_rdata = '0;
   end
   always @(posedge clk) begin
      if (mem_req) begin
         if (mem_we) begin
            for (int b = 0; b < 4; b++)
               if (mem_be[b]) mem[mem_addr[9:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            mem_rdata <= '0;
         end else begin
            mem_rdata <= mem[mem_addr[9:2]];
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic idle();
      i_req_valid = 0; i_req_addr = 0; i_flush = 0;
      d_req_valid = 0; d_req_we = 0; d_req_addr = 0; d_req_wdata = 0; d_req_be = 0;
   endtask

   task automatic next_cycle();
      @(posedge clk); #1;
   endtask

   typedef struct {
      string       nm;
      logic        iv;  logic [31:0] ia;  logic fl;
      logic        dv;  logic dwe; logic [31:0] da; logic [31:0] dwd; logic [3:0] dbe;
      logic        e_ir; logic e_dr; logic e_mreq; logic e_mwe;
      logic [31:0] e_maddr; logic [31:0] e_mwd; logic [3:0] e_mbe;
      logic        e_irv; logic e_ierr; logic [31:0] e_ird;
      logic        e_drv; logic e_derr; logic [31:0] e_drd;
   } vec_t;

   vec_t vecs [12];

   initial begin
      vecs[0]  = '{"d_rd",      0, 32'h0,    0, 1, 0, 32'h100,  32'h0,        4'h0,
                   0, 1, 1, 0, 32'h100,  32'h0,        4'h0, 0, 0, 32'h0,        1, 0, 32'hA000_0040};
      vecs[1]  = '{"i_fetch",   1, 32'h40,   0, 0, 0, 32'h0,    32'h0,        4'h0,
                   1, 0, 1, 0, 32'h40,   32'h0,        4'h0, 1, 0, 32'hA000_0010, 0, 0, 32'h0};
      vecs[2]  = '{"i_unalign", 1, 32'h43,   0, 0, 0, 32'h0,    32'h0,        4'h0,
                   1, 0, 1, 0, 32'h40,   32'h0,        4'h0, 1, 0, 32'hA000_0010, 0, 0, 32'h0};
      vecs[3]  = '{"both",      1, 32'h40,   0, 1, 0, 32'h100,  32'h0,        4'h0,
                   0, 1, 1, 0, 32'h100,  32'h0,        4'h0, 0, 0, 32'h0,        1, 0, 32'hA000_0040};
      vecs[4]  = '{"d_wr",      0, 32'h0,    0, 1, 1, 32'h10,   32'hDEADBEEF, 4'b0011,
                   0, 1, 1, 1, 32'h10,   32'hDEADBEEF, 4'b0011, 0, 0, 32'h0,    1, 0, 32'h0};
      vecs[5]  = '{"d_rd_back", 0, 32'h0,    0, 1, 0, 32'h10,   32'h0,        4'h0,
                   0, 1, 1, 0, 32'h10,   32'h0,        4'h0, 0, 0, 32'h0,        1, 0, 32'hA000_BEEF};
      vecs[6]  = '{"i_oor",     1, 32'h4000, 0, 0, 0, 32'h0,    32'h0,        4'h0,
                   1, 0, 0, 0, 32'h0,    32'h0,        4'h0, 1, 1, 32'h0000_0013, 0, 0, 32'h0};
      vecs[7]  = '{"d_oor",     0, 32'h0,    0, 1, 0, 32'h3FFE, 32'h0,        4'h0,
                   0, 1, 0, 0, 32'h0,    32'h0,        4'h0, 0, 0, 32'h0,        1, 1, 32'h0};
      vecs[8]  = '{"d_top",     0, 32'h0,    0, 1, 0, 32'h3FFC, 32'h0,        4'h0,
                   0, 1, 1, 0, 32'h3FFC, 32'h0,        4'h0, 0, 0, 32'h0,        1, 0, 32'hA000_00FF};
      vecs[9]  = '{"i_top",     1, 32'h3FFC, 0, 0, 0, 32'h0,    32'h0,        4'h0,
                   1, 0, 1, 0, 32'h3FFC, 32'h0,        4'h0, 1, 0, 32'hA000_00FF, 0, 0, 32'h0};
      vecs[10] = '{"i_flushed", 1, 32'h40,   1, 0, 0, 32'h0,    32'h0,        4'h0,
                   0, 0, 0, 0, 32'h0,    32'h0,        4'h0, 0, 0, 32'h0,        0, 0, 32'h0};
      vecs[11] = '{"d_wr_oor",  0, 32'h0,    0, 1, 1, 32'h4000, 32'h1234,     4'hF,
                   0, 1, 0, 0, 32'h0,    32'h0,        4'h0, 0, 0, 32'h0,        1, 1, 32'h0};

      // Reset: outputs all zero in the reset cycle and the one after.
      idle();
      reset = 1; i_req_valid = 1; i_req_addr = 32'h40; d_req_valid = 1; d_req_addr = 32'h100;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         chk("rst_i_ready", {31'b0, i_req_ready}, 0);
         chk("rst_d_ready", {31'b0, d_req_ready}, 0);
         chk("rst_mem_req", {31'b0, mem_req}, 0);
         chk("rst_rsp_v",   {30'b0, i_rsp_valid, d_rsp_valid}, 0);
         chk("rst_rdata",   i_rsp_rdata | d_rsp_rdata | mem_addr, 0);
         next_cycle();
      end
      reset = 0; idle();
      next_cycle();

      // Table: grant-cycle outputs, then the response in the following idle cycle.
      for (int v = 0; v < 12; v++) begin
         i_req_valid = vecs[v].iv; i_req_addr = vecs[v].ia; i_flush = vecs[v].fl;
         d_req_valid = vecs[v].dv; d_req_we = vecs[v].dwe; d_req_addr = vecs[v].da;
         d_req_wdata = vecs[v].dwd; d_req_be = vecs[v].dbe;
         @(negedge clk);
         chk({vecs[v].nm, ".i_ready"},  {31'b0, i_req_ready}, {31'b0, vecs[v].e_ir});
         chk({vecs[v].nm, ".d_ready"},  {31'b0, d_req_ready}, {31'b0, vecs[v].e_dr});
         chk({vecs[v].nm, ".mem_req"},  {31'b0, mem_req},     {31'b0, vecs[v].e_mreq});
         chk({vecs[v].nm, ".mem_we"},   {31'b0, mem_we},      {31'b0, vecs[v].e_mwe});
         chk({vecs[v].nm, ".mem_addr"}, mem_addr,  vecs[v].e_maddr);
         chk({vecs[v].nm, ".mem_wdata"}, mem_wdata, vecs[v].e_mwd);
         chk({vecs[v].nm, ".mem_be"},   {28'b0, mem_be},      {28'b0, vecs[v].e_mbe});
         next_cycle();
         idle();
         @(negedge clk);
         chk({vecs[v].nm, ".i_rsp_v"},   {31'b0, i_rsp_valid}, {31'b0, vecs[v].e_irv});
         chk({vecs[v].nm, ".i_rsp_err"}, {31'b0, i_rsp_err},   {31'b0, vecs[v].e_ierr});
         chk({vecs[v].nm, ".i_rdata"},   i_rsp_rdata, vecs[v].e_ird);
         chk({vecs[v].nm, ".d_rsp_v"},   {31'b0, d_rsp_valid}, {31'b0, vecs[v].e_drv});
         chk({vecs[v].nm, ".d_rsp_err"}, {31'b0, d_rsp_err},   {31'b0, vecs[v].e_derr});
         chk({vecs[v].nm, ".d_rdata"},   d_rsp_rdata, vecs[v].e_drd);
         next_cycle();
      end

      // Both requesters valid continuously.
      begin
         logic prev_i;
         logic exp_i;
         prev_i = 0;
         for (int k = 0; k < 11; k++) begin
            if (k < 10) begin
               i_req_valid = 1; i_req_addr = 32'h40; d_req_valid = 1; d_req_addr = 32'h100;
            end else begin
               idle();
            end
            @(negedge clk);
`ifdef MEM_ARB_STARVE_GUARD_EN
            exp_i = (k < 10) && (k % 5 == 4);
`else
            exp_i = 1'b0;
`endif
            if (k < 10) begin
               chk("prio.i_ready", {31'b0, i_req_ready}, {31'b0, exp_i});
               chk("prio.d_ready", {31'b0, d_req_ready}, {31'b0, !exp_i});
            end
            if (k > 0) begin
               chk("prio.i_rsp_v", {31'b0, i_rsp_valid}, {31'b0, prev_i});
               chk("prio.d_rsp_v", {31'b0, d_rsp_valid}, {31'b0, !prev_i});
               chk("prio.rdata", prev_i ? i_rsp_rdata : d_rsp_rdata,
                   prev_i ? 32'hA000_0010 : 32'hA000_0040);
            end
            prev_i = exp_i;
            next_cycle();
         end
      end

      // Flush: I granted, then flushed while D is granted.
      i_req_valid = 1; i_req_addr = 32'h40;
      @(negedge clk);
      chk("flush.i_grant", {31'b0, i_req_ready}, 1);
      next_cycle();
      i_flush = 1; d_req_valid = 1; d_req_addr = 32'h100;
      @(negedge clk);
      chk("flush.i_rsp_v", {31'b0, i_rsp_valid}, 0);
      chk("flush.i_ready", {31'b0, i_req_ready}, 0);
      chk("flush.d_ready", {31'b0, d_req_ready}, 1);
      chk("flush.mem_addr", mem_addr, 32'h100);
      next_cycle();
      idle();
      @(negedge clk);
      chk("flush.d_rsp_v", {31'b0, d_rsp_valid}, 1);
      chk("flush.d_rdata", d_rsp_rdata, 32'hA000_0040);
      chk("flush.i_rsp_v2", {31'b0, i_rsp_valid}, 0);
      next_cycle();

      // Reset while a D read response is due.
      d_req_valid = 1; d_req_addr = 32'h100;
      @(negedge clk);
      chk("rstmid.d_grant", {31'b0, d_req_ready}, 1);
      next_cycle();
      reset = 1; i_req_valid = 1; i_req_addr = 32'h40;
      @(negedge clk);
      chk("rstmid.d_rsp_v", {31'b0, d_rsp_valid}, 0);
      chk("rstmid.d_rdata", d_rsp_rdata, 0);
      chk("rstmid.ready", {30'b0, i_req_ready, d_req_ready}, 0);
      chk("rstmid.mem_req", {31'b0, mem_req}, 0);
      next_cycle();
      reset = 0; idle();
      @(negedge clk);
      chk("rstmid.rsp_after", {30'b0, i_rsp_valid, d_rsp_valid}, 0);
      next_cycle();
      i_req_valid = 1; i_req_addr = 32'h40; d_req_valid = 1; d_req_addr = 32'h100;
      @(negedge clk);
      chk("rstmid.d_first", {30'b0, i_req_ready, d_req_ready}, 32'h1);
      next_cycle();
      idle();
      next_cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
